countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable N-bit down counter; the decrementing counterpart of the team's free-running up counter.
- Counts a programmed value down to zero under a start/enable/stop control set.
- Flags terminal count with a one-cycle pulse and supports optional auto-reload for periodic ticks.
- Sits beside `counter_nbit` in the sequential library; used for timeouts, tick generation and delay gating.

Parameters:
- N, 8, counter and load-value width in bits (N >= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset.
- load  input  1  capture load_val into count and reload registers.
- load_val  input  N  value to count down from.
- start  input  1  begin counting (IDLE only).
- en  input  1  decrement qualifier in RUN; low = pause, count holds.
- stop  input  1  abort RUN, return to IDLE, count holds.
- auto_reload  input  1  at terminal count, reload and keep running instead of stopping.
- q  output  N  current count.
- busy  output  1  high while state = RUN.
- done  output  1  one-cycle terminal-count pulse.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. On a clk edge with rst=1: q=0, reload_reg=0, busy=0, done=0, state=IDLE. This overrides all other inputs, including mid-run; no done pulse is produced.
- States: IDLE, RUN. busy = (state==RUN), registered along with the state.
- done is registered. Its default value each cycle is 0.
- IDLE, load=1: q<=load_val, reload_reg<=load_val.
- IDLE, start=1:
  - Value used is load_val if load is also asserted in the same cycle, else q.
  - Value != 0: go to RUN.
  - Value == 0: stay IDLE, done<=1 next cycle (zero-length count).
- RUN, en=0: q, state hold.
- RUN, en=1, q>1: q<=q-1.
- RUN, en=1, q==1 (terminal):
  - done<=1.
  - auto_reload=1 and reload_reg!=0: q<=reload_reg, stay RUN.
  - Otherwise: q<=0, go to IDLE.
- RUN, stop=1: go to IDLE, q holds, no done. stop beats terminal count in the same cycle.
- RUN: load and start are ignored. auto_reload is sampled only at terminal count.
- Latency:
  - start sampled at edge t (en held high, value L): state=RUN after edge t.
  - Decrements occur at edges t+1 .. t+L.
  - done and q=0 are visible in the cycle following edge t+L, i.e. L+1 cycles after start.
  - Each en=0 cycle adds one cycle.
- Periodic mode: done pulses every L cycles with en held high. q sequence is L, L-1, ..., 1, L, ...; 0 is never shown.
- Arithmetic: unsigned N-bit. q never underflows (1 is the lowest value decremented). Max count 2^N-1.

Optional Feature:
- Macro: COUNTDOWN_TIMER_EVT_CNT_EN.
- Defined:
  - Adds output done_cnt [7:0], counting done pulses and saturating at 255.
  - Cleared to 0 by rst and by an accepted load.
  - Increments in the cycle after done is set; reads 1 when the first done is visible.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package countdown_pkg:
  - typedef enum logic {CDT_IDLE, CDT_RUN} cdt_state_e.
  - localparam EVT_CNT_W = 8.
- Main module is flat.
- One natural sub-module: sat_event_cnt (saturating up counter with clear). Instantiated only under COUNTDOWN_TIMER_EVT_CNT_EN.

Test Plan:
- Reset mid-run: load 200, start, run 10 cycles, assert rst -> next cycle q=0, busy=0, done=0, no done pulse afterwards.
- Basic countdown: load 5, start next cycle, en=1 -> q goes 5,4,3,2,1,0; done is high only in the cycle q=0, which is 6 cycles after start; busy drops the same cycle.
- Pause and abort:
  - load 4, start, drop en for 3 cycles at q=2 -> q holds at 2, done is delayed 3 cycles.
  - Separate run: stop at q=1 together with en=1 -> q stays 1, state IDLE, no done.
- Auto-reload: load 3, auto_reload=1, start -> done pulses every 3 cycles, q cycles 3,2,1,3,...; deassert auto_reload -> next terminal gives q=0, IDLE.
- Zero and corner cases:
  - load+start same cycle with load_val=0 -> one done pulse, busy never asserts.
  - load_val=255 (N=8) -> done 256 cycles after start.
  - start while busy -> ignored, count is undisturbed.
- EVT_CNT_EN build: auto-reload with L=2 for 600 cycles -> done_cnt saturates at 255; a load clears it to 0.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer and its optional done-event counter.
// Optional event counter is enabled with COUNTDOWN_TIMER_EVT_CNT_EN.
package countdown_pkg;

  typedef enum logic {
    CDT_IDLE = 1'b0,
    CDT_RUN  = 1'b1
  } cdt_state_e;

  localparam int EVT_CNT_W = 8;

endpackage : countdown_pkg

// File: rtl/sat_event_cnt.sv
// Saturating up counter with synchronous clear; a simultaneous clear and
// increment yields 1 so the clearing event itself is still counted.
module sat_event_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] r_cnt;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= inc ? ONE : '0;
    end else if (inc) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  assign cnt = r_cnt;

endmodule : sat_event_cnt

// File: rtl/countdown_timer.sv
// Loadable N-bit down counter with start/en/stop control, one-cycle done pulse
// and auto-reload; COUNTDOWN_TIMER_EVT_CNT_EN adds a saturating done_cnt output.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [N-1:0]         load_val,
  input  logic                 start,
  input  logic                 en,
  input  logic                 stop,
  input  logic                 auto_reload,
  output logic [N-1:0]         q,
  output logic                 busy,
  output logic                 done
`ifdef COUNTDOWN_TIMER_EVT_CNT_EN
  ,
  output logic [EVT_CNT_W-1:0] done_cnt
`endif
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  cdt_state_e   r_state;
  logic [N-1:0] r_q;
  logic [N-1:0] r_reload;
  logic         r_busy;
  logic         r_done;

  logic [N-1:0] w_start_val;
  logic         w_start_go;
  logic         w_zero_start;
  logic         w_terminal;
  logic         w_reload_ok;
  logic         w_done_set;

  // A same-cycle load supplies the start value; otherwise the held count does.
  assign w_start_val  = load ? load_val : r_q;
  assign w_start_go   = (r_state == CDT_IDLE) && start && (w_start_val != '0);
  assign w_zero_start = (r_state == CDT_IDLE) && start && (w_start_val == '0);
  // q <= 1 rather than q == 1 so an unreachable zero in RUN can never wrap.
  assign w_terminal   = (r_state == CDT_RUN) && !stop && en && (r_q <= ONE);
  assign w_reload_ok  = auto_reload && (r_reload != '0);
  assign w_done_set   = w_zero_start || w_terminal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= CDT_IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done_set;
      case (r_state)
        CDT_IDLE: begin
          if (load) begin
            r_q      <= load_val;
            r_reload <= load_val;
          end
          if (w_start_go) begin
            r_state <= CDT_RUN;
            r_busy  <= 1'b1;
          end
        end
        CDT_RUN: begin
          if (stop) begin
            r_state <= CDT_IDLE;
            r_busy  <= 1'b0;
          end else if (en) begin
            if (!w_terminal) begin
              r_q <= r_q - ONE;
            end else if (w_reload_ok) begin
              r_q <= r_reload;
            end else begin
              r_q     <= '0;
              r_state <= CDT_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= CDT_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign q    = r_q;
  assign busy = r_busy;
  assign done = r_done;

`ifdef COUNTDOWN_TIMER_EVT_CNT_EN
  logic w_load_acc;

  assign w_load_acc = (r_state == CDT_IDLE) && load;

  sat_event_cnt #(
    .W (EVT_CNT_W)
  ) u_evt_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_load_acc),
    .inc (w_done_set),
    .cnt (done_cnt)
  );
`endif

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; define COUNTDOWN_TIMER_EVT_CNT_EN to
// also exercise the done_cnt output.
module tb_countdown_timer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [N-1:0] load_val;
  logic         start;
  logic         en;
  logic         stop;
  logic         auto_reload;
  logic [N-1:0] q;
  logic         busy;
  logic         done;
`ifdef COUNTDOWN_TIMER_EVT_CNT_EN
  logic [7:0]   done_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_done;

  always #5 clk = ~clk;

  countdown_timer #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .en          (en),
    .stop        (stop),
    .auto_reload (auto_reload),
    .q           (q),
    .busy        (busy),
    .done        (done)
`ifdef COUNTDOWN_TIMER_EVT_CNT_EN
    ,
    .done_cnt    (done_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"}, 32'(q), eq);
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    rst = 1'b1; load = 1'b1; load_val = 8'd77; start = 1'b1;
    en = 1'b1; stop = 1'b0; auto_reload = 1'b0;
    step(); step();
    chk3("reset", 0, 1'b0, 1'b0);
`ifdef COUNTDOWN_TIMER_EVT_CNT_EN
    chk("reset.done_cnt", 32'(done_cnt), 0);
`endif
    rst = 1'b0; load = 1'b0; start = 1'b0;
    step();
    chk3("idle_after_reset", 0, 1'b0, 1'b0);

    // Basic countdown from 5
    load = 1'b1; load_val = 8'd5;
    step();
    chk3("basic.load", 5, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    step();
    chk3("basic.start", 5, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk3("basic.count", 32'(5 - i), 1'b1, 1'b0);
    end
    step();
    chk3("basic.terminal", 0, 1'b0, 1'b1);
`ifdef COUNTDOWN_TIMER_EVT_CNT_EN
    chk("basic.done_cnt", 32'(done_cnt), 1);
`endif
    step();
    chk3("basic.after", 0, 1'b0, 1'b0);

    // Reset mid-run
    load = 1'b1; load_val = 8'd200;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk3("midrun.before_rst", 190, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk3("midrun.rst", 0, 1'b0, 1'b0);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) n_done++;
    end
    chk("midrun.no_done", 32'(n_done), 0);
    chk3("midrun.idle", 0, 1'b0, 1'b0);

    // Pause: en low for 3 cycles at q=2
    load = 1'b1; load_val = 8'd4;
    step();
    load = 1'b0; start = 1'b1;
    step();
    chk3("pause.start", 4, 1'b1, 1'b0);
    start = 1'b0;
    step(); step();
    chk3("pause.at2", 2, 1'b1, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk3("pause.hold", 2, 1'b1, 1'b0);
    end
    en = 1'b1;
    step();
    chk3("pause.resume", 1, 1'b1, 1'b0);
    step();
    chk3("pause.terminal", 0, 1'b0, 1'b1);

    // Stop at q=1 together with en: stop wins over terminal
    load = 1'b1; load_val = 8'd3;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk3("stop.at1", 1, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    chk3("stop.abort", 1, 1'b0, 1'b0);
    stop = 1'b0;
    step();
    chk3("stop.after", 1, 1'b0, 1'b0);

    // Auto-reload with L=3
    auto_reload = 1'b1;
    load = 1'b1; load_val = 8'd3;
    step();
    load = 1'b0; start = 1'b1;
    step();
    chk3("arl.start", 3, 1'b1, 1'b0);
    start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      step(); chk3("arl.q2", 2, 1'b1, 1'b0);
      step(); chk3("arl.q1", 1, 1'b1, 1'b0);
      step(); chk3("arl.reload", 3, 1'b1, 1'b1);
    end
    auto_reload = 1'b0;
    step(); chk3("arl_off.q2", 2, 1'b1, 1'b0);
    step(); chk3("arl_off.q1", 1, 1'b1, 1'b0);
    step(); chk3("arl_off.terminal", 0, 1'b0, 1'b1);
    step(); chk3("arl_off.after", 0, 1'b0, 1'b0);

    // Zero-length count: load+start with 0
    load = 1'b1; load_val = 8'd0; start = 1'b1;
    step();
    chk3("zero.pulse", 0, 1'b0, 1'b1);
    load = 1'b0; start = 1'b0;
    step();
    chk3("zero.after", 0, 1'b0, 1'b0);

    // Max count 255, with start and load asserted while busy
    load = 1'b1; load_val = 8'd255;
    step();
    load = 1'b0; start = 1'b1;
    step();
    chk3("max.start", 255, 1'b1, 1'b0);
    load = 1'b1; load_val = 8'd7;
    step();
    chk3("max.start_busy1", 254, 1'b1, 1'b0);
    step();
    chk3("max.start_busy2", 253, 1'b1, 1'b0);
    load = 1'b0; start = 1'b0;
    n_done = 0;
    for (int i = 3; i <= 254; i++) begin
      step();
      if (done) n_done++;
    end
    chk("max.no_early_done", 32'(n_done), 0);
    chk3("max.at1", 1, 1'b1, 1'b0);
    step();
    chk3("max.terminal", 0, 1'b0, 1'b1);

`ifdef COUNTDOWN_TIMER_EVT_CNT_EN
    // Event counter saturation and clear
    auto_reload = 1'b1;
    load = 1'b1; load_val = 8'd2;
    step();
    chk("evt.cleared", 32'(done_cnt), 0);
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); chk3("evt.q1", 1, 1'b1, 1'b0);
    step(); chk3("evt.first", 2, 1'b1, 1'b1);
    chk("evt.first_cnt", 32'(done_cnt), 1);
    for (int i = 0; i < 600; i++) step();
    chk("evt.saturated", 32'(done_cnt), 255);
    auto_reload = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0; load = 1'b1; load_val = 8'd9;
    step();
    load = 1'b0;
    chk("evt.load_clear", 32'(done_cnt), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_countdown_timer
